// File: rtl/mem_responder.sv
// Word-wide memory responder with a programmable number of wait states.
// One access is accepted in IDLE. It waits LATENCY cycles, then completes
// with a single-cycle ready pulse. Misaligned or out-of-range addresses
// complete with err=1, perform no write and return zero read data.
module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  // Access that completes on this edge. With zero latency the accept edge
  // is also the completion edge, so the live inputs are used directly.
  logic             acc_we;
  logic [31:0]      acc_adr;
  logic [31:0]      acc_wdata;
  logic             acc_bad;
  logic [IDX_W-1:0] acc_idx;
  logic             complete;
  logic             mem_we;

  // Select the access being completed and classify its address.
  always_comb begin
    acc_we    = we_q;
    acc_adr   = adr_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_we    = we;
      acc_adr   = Adr;
      acc_wdata = WriteData;
    end
    // The full word address is compared so high bits never alias into range.
    acc_bad  = (acc_adr[1:0] != 2'b00) || ({2'b00, acc_adr[31:2]} >= 32'(DEPTH));
    acc_idx  = acc_adr[IDX_W+1:2];
    complete = ((LATENCY == 0) && (state_q == IDLE) && req) ||
               ((state_q == WAIT) && (cnt_q == 4'd0));
    mem_we   = complete && acc_we && !acc_bad;
  end

  // Next-state, wait counter, capture registers and completion results.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          adr_d   = Adr;
          wdata_d = WriteData;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (complete) begin
      err_d = acc_bad;
      if (acc_bad) begin
        read_data_d = 32'd0;
      end else if (!acc_we) begin
        read_data_d = mem[acc_idx];
      end
    end
  end

  // State and result registers. The memory array is written from the
  // non-reset branch only, so a reset can never commit a pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      adr_q       <= 32'd0;
      wdata_q     <= 32'd0;
      read_data_q <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      err_q       <= err_d;
      if (mem_we) begin
        mem[acc_idx] <= acc_wdata;
      end
    end
  end

  assign ReadData = read_data_q;
  assign ready    = (state_q == RESP);
  assign err      = err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances with LATENCY 0..3 share the data
// inputs. Each instance has its own req and reset. Expected results come
// from a per-instance array model of memory contents and last read data.
module tb_mem_responder;

  localparam int NI    = 4;
  localparam int DEPTH = 64;

  logic        clk;
  logic        rst_s  [NI];
  logic        req_s  [NI];
  logic        we_s;
  logic [31:0] adr_s;
  logic [31:0] wd_s;
  logic [31:0] rd_o   [NI];
  logic        ready_o[NI];
  logic        err_o  [NI];
  logic        busy_o [NI];

  logic [31:0] model_mem [NI][DEPTH];
  logic [31:0] model_rd  [NI];
  int          checks;
  int          errors;
  int          edge_cnt;
  int          accept_edge [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    mem_responder #(.DEPTH(DEPTH), .LATENCY(gi)) u_dut (
      .clk      (clk),
      .reset    (rst_s[gi]),
      .req      (req_s[gi]),
      .we       (we_s),
      .Adr      (adr_s),
      .WriteData(wd_s),
      .ReadData (rd_o[gi]),
      .ready    (ready_o[gi]),
      .err      (err_o[gi]),
      .busy     (busy_o[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  // One access on instance i, with expectations taken from the model.
  // Inputs are scrambled right after the accept edge, so completion has
  // to use the values captured at that edge.
  task automatic access(input int i, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic hold);
    logic        bad;
    logic [31:0] exp_rd;
    int          lat;
    lat = i;
    bad = addr_bad(a);
    if (bad)     exp_rd = 32'd0;
    else if (w)  exp_rd = model_rd[i];
    else         exp_rd = model_mem[i][int'(a >> 2)];

    @(negedge clk);
    we_s = w; adr_s = a; wd_s = d; req_s[i] = 1'b1;
    @(posedge clk);
    #1;
    accept_edge[i] = edge_cnt;
    if (!hold) req_s[i] = 1'b0;
    we_s = 1'($urandom); adr_s = $urandom; wd_s = $urandom;

    for (int c = 0; c <= lat; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      checks++;
      if (ready_o[i] !== (c == lat)) begin
        errors++;
        $display("FAIL ready inst%0d cycle E0+%0d: got %b want %b", i, c + 1, ready_o[i], (c == lat));
      end
      checks++;
      if (busy_o[i] !== 1'b1) begin
        errors++;
        $display("FAIL busy inst%0d cycle E0+%0d: got %b want 1", i, c + 1, busy_o[i]);
      end
      if (c < lat) begin
        checks++;
        if (err_o[i] !== 1'b0) begin
          errors++;
          $display("FAIL err_idle inst%0d: got %b want 0", i, err_o[i]);
        end
      end
    end
    checks++;
    if (err_o[i] !== bad) begin
      errors++;
      $display("FAIL err inst%0d adr %h: got %b want %b", i, a, err_o[i], bad);
    end
    checks++;
    if (rd_o[i] !== exp_rd) begin
      errors++;
      $display("FAIL ReadData inst%0d adr %h: got %h want %h", i, a, rd_o[i], exp_rd);
    end
    $display("inst%0d %s adr=%h wdata=%h -> ReadData=%h err=%b", i, w ? "WR" : "RD", a, d, rd_o[i], err_o[i]);

    if (!bad && w) model_mem[i][int'(a >> 2)] = d;
    model_rd[i] = exp_rd;

    @(posedge clk);
    #1;
    checks++;
    if ({ready_o[i], busy_o[i], err_o[i]} !== 3'b000) begin
      errors++;
      $display("FAIL after_resp inst%0d: ready/busy/err got %b want 000", i, {ready_o[i], busy_o[i], err_o[i]});
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({rd_o[i], ready_o[i], err_o[i], busy_o[i]} !== 35'd0) begin
        errors++;
        $display("FAIL reset inst%0d: rd=%h ready=%b err=%b busy=%b want all 0", i, rd_o[i], ready_o[i], err_o[i], busy_o[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) rst_s[i] = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({ready_o[i], busy_o[i]} !== 2'b00) begin
        errors++;
        $display("FAIL idle_after_reset inst%0d: ready/busy %b want 00", i, {ready_o[i], busy_o[i]});
      end
    end
  endtask

  // Give every word of every instance a known value.
  task automatic test_fill();
    for (int i = 0; i < NI; i++)
      for (int w = 0; w < DEPTH; w++)
        access(i, 1'b1, 32'(w * 4), $urandom, 1'b0);
  endtask

  task automatic test_latency2();
    access(2, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    access(2, 1'b0, 32'h10, 32'h0, 1'b0);
    checks++;
    if (model_rd[2] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lat2_readback: model %h want deadbeef", model_rd[2]);
    end
  endtask

  task automatic test_latency0();
    access(0, 1'b1, 32'h04, 32'h12345678, 1'b0);
    access(0, 1'b0, 32'h04, 32'h0, 1'b0);
  endtask

  task automatic test_errors();
    access(2, 1'b0, 32'h13, 32'h0, 1'b0);
    access(2, 1'b1, 32'h100, $urandom, 1'b0);
    access(2, 1'b1, 32'h8000_0000, $urandom, 1'b0);
    access(2, 1'b0, 32'h00, 32'h0, 1'b0);
    access(3, 1'b1, 32'h0000_0102, $urandom, 1'b0);
    access(3, 1'b0, 32'h00, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int prev;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      access(1, (k % 2) == 0, 32'h08, 32'hA5A5A5A5, 1'b1);
      if (k > 0) begin
        checks++;
        if (accept_edge[1] - prev !== 3) begin
          errors++;
          $display("FAIL accept_spacing: got %0d edges want 3", accept_edge[1] - prev);
        end
      end
      prev = accept_edge[1];
    end
    req_s[1] = 1'b0;
    checks++;
    if (rd_o[1] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL b2b_read: got %h want a5a5a5a5", rd_o[1]);
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    we_s = 1'b1; adr_s = 32'h20; wd_s = 32'h11111111; req_s[3] = 1'b1;
    @(posedge clk);
    #1;
    req_s[3] = 1'b0;
    checks++;
    if (busy_o[3] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy_before: got %b want 1", busy_o[3]);
    end
    #2;
    rst_s[3] = 1'b1;
    #1;
    checks++;
    if ({rd_o[3], ready_o[3], err_o[3], busy_o[3]} !== 35'd0) begin
      errors++;
      $display("FAIL midrst_outputs: rd=%h ready=%b err=%b busy=%b want all 0", rd_o[3], ready_o[3], err_o[3], busy_o[3]);
    end
    model_rd[3] = 32'd0;
    @(posedge clk);
    @(negedge clk);
    rst_s[3] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({ready_o[3], busy_o[3]} !== 2'b00) begin
        errors++;
        $display("FAIL midrst_no_pulse cycle %0d: ready/busy %b want 00", c, {ready_o[3], busy_o[3]});
      end
    end
    access(3, 1'b0, 32'h20, 32'h0, 1'b0);
    checks++;
    if (rd_o[3] === 32'h11111111) begin
      errors++;
      $display("FAIL midrst_write_committed: got %h want old value %h", rd_o[3], model_mem[3][8]);
    end
  endtask

  task automatic test_random();
    int          i, r;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      i = $urandom_range(0, NI - 1);
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(0, DEPTH - 1) << 2) | 32'($urandom_range(1, 3));
      else if (r == 1) a = ($urandom & 32'hFFFF_FFFC) | 32'h100;
      else             a = 32'($urandom_range(0, DEPTH - 1) << 2);
      access(i, 1'($urandom), a, $urandom, 1'b0);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    edge_cnt = 0;
    we_s     = 1'b0;
    adr_s    = 32'd0;
    wd_s     = 32'd0;
    for (int i = 0; i < NI; i++) begin
      rst_s[i]       = 1'b1;
      req_s[i]       = 1'b0;
      model_rd[i]    = 32'd0;
      accept_edge[i] = 0;
    end
    #2;
    test_reset();
    test_fill();
    test_latency2();
    test_latency0();
    test_errors();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
